// File: rtl/periph_pkg.sv
// Shared types and register-map constants for the peripheral controller.
package periph_pkg;

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [4:0] OFF_SW   = 5'h00;
  localparam logic [4:0] OFF_LED  = 5'h04;
  localparam logic [4:0] OFF_CNT  = 5'h08;
  localparam logic [4:0] OFF_CTRL = 5'h0C;
  localparam logic [4:0] OFF_CMP  = 5'h10;

  localparam int EN_BIT   = 0;
  localparam int PEND_BIT = 1;

endpackage

// File: rtl/periph_ctrl_sw_debounce.sv
// Switch input conditioning: 2-flop synchroniser followed by a per-bit
// stability counter; a bit changes only after DEBOUNCE_CYC differing samples.
module sw_debounce #(
  parameter int N            = 10,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw,
  output logic [N-1:0] stable
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [N-1:0]  sync1, sync2;
  logic [CW-1:0] cnt [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < N; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
            stable[i] <= ~stable[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/periph_ctrl.sv
// Memory-mapped switch/LED/timer peripheral with a valid/ready request and a
// registered one-cycle response; one access every two cycles.
module periph_ctrl
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hC000_0000,
  parameter int          N_SW         = 10,
  parameter int          N_LED        = 10,
  parameter int          DEBOUNCE_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  input  logic [N_SW-1:0]  switches,
  output logic [N_LED-1:0] leds,
  output logic             timer_irq
);

  state_t          state;
  logic [N_SW-1:0] sw_stable;
  logic [31:0]     tmr_cnt, tmr_cmp, rd_mux;
  logic            tmr_en, tmr_pend, tmr_match, addr_ok, accept;
  logic [4:0]      off;

  sw_debounce #(.N(N_SW), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw    (switches),
    .stable (sw_stable)
  );

  assign off       = req_addr[4:0];
  assign addr_ok   = (req_addr[31:5] == BASE_ADDR[31:5]) && (req_addr[1:0] == 2'b00)
                     && (off <= OFF_CMP);
  assign accept    = (state == IDLE) && req_valid;
  assign tmr_match = tmr_en && (tmr_cnt == tmr_cmp);
  assign timer_irq = tmr_pend;

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_SW:   rd_mux = 32'(sw_stable);
      OFF_LED:  rd_mux = 32'(leds);
      OFF_CNT:  rd_mux = tmr_cnt;
      OFF_CTRL: rd_mux = {30'd0, tmr_pend, tmr_en};
      OFF_CMP:  rd_mux = tmr_cmp;
      default:  rd_mux = '0;
    endcase
  end

  // NOTE: non-blocking throughout, so reads, the compare and W1C all see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      leds      <= '0;
      tmr_cnt   <= '0;
      tmr_cmp   <= '1;
      tmr_en    <= 1'b0;
      tmr_pend  <= 1'b0;
    end else begin
      if (tmr_en) tmr_cnt <= tmr_match ? '0 : tmr_cnt + 32'd1;

      // A match beats a same-cycle W1C clear.
      if (tmr_match) tmr_pend <= 1'b1;
      else if (accept && addr_ok && req_we && off == OFF_CTRL && req_wdata[PEND_BIT])
        tmr_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~addr_ok;
            rsp_rdata <= (addr_ok && !req_we) ? rd_mux : '0;
            if (addr_ok && req_we) begin
              case (off)
                OFF_LED:  leds    <= req_wdata[N_LED-1:0];
                OFF_CTRL: tmr_en  <= req_wdata[EN_BIT];
                OFF_CMP:  tmr_cmp <= req_wdata;
                default:  ;
              endcase
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_ctrl.sv
// Self-checking bench for periph_ctrl: a cycle-level behavioural model compared
// every cycle, plus directed accesses with hand-computed literal expectations.
module tb_periph_ctrl;

  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam int          DEB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, timer_irq;
  logic [31:0] rsp_rdata;
  logic [9:0]  switches = '0;
  logic [9:0]  leds;

  int n_pass = 0, n_total = 0;
  bit started = 1'b0;

  periph_ctrl #(.BASE_ADDR(BASE), .N_SW(10), .N_LED(10), .DEBOUNCE_CYC(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .switches  (switches),
    .leds      (leds),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_rv, m_err, m_en, m_pend;
  logic [31:0] m_rd, m_cnt, m_cmp;
  logic [9:0]  m_leds, m_sw;
  logic [9:0]  hist [0:DEB+1];

  always @(posedge clk) begin : model
    logic [31:0] o;
    bit ok, match, do_w, diff;
    if (reset) begin
      m_busy = 0; m_rv = 0; m_err = 0; m_rd = '0;
      m_leds = '0; m_en = 0; m_pend = 0; m_cnt = '0; m_cmp = '1; m_sw = '0;
      for (int k = 0; k <= DEB + 1; k++) hist[k] = '0;
    end else begin
      o     = req_addr - BASE;
      ok    = (o < 32) && (o % 4 == 0) && (o <= 16);
      match = m_en && (m_cnt == m_cmp);
      do_w  = 0;
      if (m_busy) begin
        m_busy = 0; m_rv = 0;
      end else if (req_valid) begin
        m_busy = 1; m_rv = 1; m_err = !ok; m_rd = '0;
        if (ok && !req_we) begin
          case (o)
            0:  m_rd = {22'd0, m_sw};
            4:  m_rd = {22'd0, m_leds};
            8:  m_rd = m_cnt;
            12: m_rd = {30'd0, m_pend, m_en};
            default: m_rd = m_cmp;
          endcase
        end
        do_w = ok && req_we;
      end
      if (match) begin m_cnt = '0; m_pend = 1; end
      else if (m_en) m_cnt = m_cnt + 1;
      if (do_w) begin
        if (o == 4)  m_leds = req_wdata[9:0];
        if (o == 12) begin
          m_en = req_wdata[0];
          if (req_wdata[1] && !match) m_pend = 0;
        end
        if (o == 16) m_cmp = req_wdata;
      end
      // A switch bit flips once its last DEB synchronised samples all disagree.
      for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = switches;
      for (int b = 0; b < 10; b++) begin
        diff = 1;
        for (int k = 2; k <= DEB + 1; k++) if (hist[k][b] == m_sw[b]) diff = 0;
        if (diff) m_sw[b] = ~m_sw[b];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ready",  {31'd0, req_ready}, {31'd0, !m_busy});
      check("rsp_v",  {31'd0, rsp_valid}, {31'd0, m_rv});
      check("rdata",  rsp_rdata, m_rd);
      check("err",    {31'd0, rsp_err}, {31'd0, m_err});
      check("leds",   {22'd0, leds}, {22'd0, m_leds});
      check("irq",    {31'd0, timer_irq}, {31'd0, m_pend});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      rd = '0; err = 1'b1;
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("rsp_strobe", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata; err = rsp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    logic        err;
    int          pulses;

    @(negedge clk); started = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    check("rst_leds",  {22'd0, leds}, 32'd0);
    check("rst_irq",   {31'd0, timer_irq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1. LED register
    access(1, BASE + 4, 32'h0000_03FF, rd, err);
    check("led_wr_now", {22'd0, leds}, 32'h3FF);
    check("led_wr_rd",  rd, 32'd0);
    check("led_wr_err", {31'd0, err}, 32'd0);
    access(0, 32'hC000_0004, '0, rd, err);
    check("led_rd", rd, 32'h3FF);
    check("led_rd_err", {31'd0, err}, 32'd0);
    access(1, BASE + 4, 32'hFFFF_F005, rd, err);
    check("led_trunc", {22'd0, leds}, 32'h005);

    // 2. switches: steady change then a short glitch
    switches = 10'd4;
    repeat (DEB + 2) @(negedge clk);
    access(0, BASE, '0, rd, err);
    check("sw_steady", rd, 32'h4);
    switches = 10'd1;
    repeat (2) @(negedge clk);
    switches = 10'd4;
    repeat (8) @(negedge clk);
    access(0, BASE, '0, rd, err);
    check("sw_glitch", rd, 32'h4);

    // 3. timer; E = accept edge of the EN write
    access(1, BASE + 16, 32'd5, rd, err);
    access(1, BASE + 12, 32'd1, rd, err);
    repeat (5) @(negedge clk);
    check("irq_before", {31'd0, timer_irq}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'd0, timer_irq}, 32'd1);
    access(0, BASE + 8, '0, rd, err);
    check("cnt_wrap", rd, 32'd0);
    access(1, BASE + 12, 32'd3, rd, err);
    check("irq_w1c", {31'd0, timer_irq}, 32'd0);
    repeat (2) @(negedge clk);
    access(1, BASE + 12, 32'd3, rd, err);
    check("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    access(1, BASE + 12, 32'd2, rd, err);
    check("irq_clear", {31'd0, timer_irq}, 32'd0);

    // 4. invalid accesses
    access(0, 32'hC000_0014, '0, rd, err);
    check("err_range", {31'd0, err}, 32'd1);
    check("err_range_rd", rd, 32'd0);
    access(0, 32'hC000_0002, '0, rd, err);
    check("err_align", {31'd0, err}, 32'd1);
    check("err_align_rd", rd, 32'd0);
    access(1, 32'hD000_0004, 32'h0000_0123, rd, err);
    check("err_window", {31'd0, err}, 32'd1);
    check("err_leds", {22'd0, leds}, 32'h005);

    // 5. back-to-back requests with valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 4;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ready", {31'd0, req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (rsp_valid) pulses++;
    end
    req_valid = 1'b0;
    check("b2b_pulses", pulses, 32'd4);

    // 6. reset during the response of a LED write
    @(negedge clk);
    access(1, BASE + 4, 32'h2AA, rd, err);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_rspv", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_leds", {22'd0, leds}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    access(0, BASE + 16, '0, rd, err);
    check("post_rst_cmp", rd, 32'hFFFF_FFFF);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
